// File: rtl/mult_acc_pkg.sv
// Shared constants, tag type and width helper for the pipelined multiply-accumulate block.
package mult_acc_pkg;

  localparam int LATENCY_MIN   = 1;
  localparam int LATENCY_MAX   = 4;
  localparam int DEF_A_WIDTH   = 18;
  localparam int DEF_B_WIDTH   = 18;
  localparam int DEF_LATENCY   = 3;
  localparam int DEF_ACC_WIDTH = 48;

  // Per-sample side information travelling alongside the product data.
  typedef struct packed {
    logic valid;
    logic clr;
  } stage_tag_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One clock-enabled pipeline register carrying {valid, clr tag, data}.
// Data only loads with a valid sample so bubbles leave the last product in place.
module mult_pipe_stage
  import mult_acc_pkg::*;
#(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  stage_tag_t       d_tag,
  input  logic [WIDTH-1:0] d_data,
  output stage_tag_t       q_tag,
  output logic [WIDTH-1:0] q_data
);

  stage_tag_t       tag_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_reg  <= '0;
      data_reg <= '0;
    end else if (ce) begin
      tag_reg.valid <= d_tag.valid;
      // A frame-start flag is meaningless without a sample behind it.
      tag_reg.clr   <= d_tag.valid & d_tag.clr;
      if (d_tag.valid) begin
        data_reg <= d_data;
      end
    end
  end

  assign q_tag  = tag_reg;
  assign q_data = data_reg;

endmodule

// File: rtl/mult_acc_pipe.sv
// Pipelined signed multiplier with valid tracking and a frame-based running accumulator.
// Define MULT_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mult_acc_pipe
  import mult_acc_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               ce,
  input  logic                               in_valid,
  input  logic signed [A_WIDTH-1:0]          a,
  input  logic signed [B_WIDTH-1:0]          b,
  input  logic                               acc_clr,
  output logic                               out_valid,
  output logic signed [A_WIDTH+B_WIDTH-1:0]  p,
  output logic                               acc_valid,
  output logic signed [ACC_WIDTH-1:0]        acc,
  output logic                               acc_ovf
);

  localparam int P_WIDTH = prod_width(A_WIDTH, B_WIDTH);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("mult_acc_pipe: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
  end
  if (ACC_WIDTH < P_WIDTH) begin : g_bad_acc_width
    $error("mult_acc_pipe: ACC_WIDTH %0d narrower than product width %0d", ACC_WIDTH, P_WIDTH);
  end

  stage_tag_t         stage_tag  [0:LATENCY];
  logic [P_WIDTH-1:0] stage_data [0:LATENCY];

  // Operands are widened to the full product width first, so the product is exact.
  assign stage_tag[0]  = '{valid: in_valid, clr: acc_clr};
  assign stage_data[0] = P_WIDTH'(a) * P_WIDTH'(b);

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    mult_pipe_stage #(
      .WIDTH(P_WIDTH)
    ) u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .ce     (ce),
      .d_tag  (stage_tag[gi]),
      .d_data (stage_data[gi]),
      .q_tag  (stage_tag[gi+1]),
      .q_data (stage_data[gi+1])
    );
  end

  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic                        acc_valid_reg;
  logic                        acc_ovf_reg;
  logic                        acc_ovf_next;
  logic                        add_ovf;

  always_comb begin
    p_ext    = ACC_WIDTH'($signed(stage_data[LATENCY]));
    acc_base = stage_tag[LATENCY].clr ? '0 : acc_reg;
    acc_sum  = acc_base + p_ext;
    // Two's-complement overflow: like-signed operands yielding an opposite-signed sum.
    add_ovf  = (acc_base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != p_ext[ACC_WIDTH-1]);
    acc_next = acc_sum;
`ifdef MULT_ACC_SAT_EN
    if (add_ovf) begin
      acc_next = p_ext[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
    acc_ovf_next = (stage_tag[LATENCY].clr ? 1'b0 : acc_ovf_reg) | add_ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      acc_valid_reg <= 1'b0;
      acc_ovf_reg   <= 1'b0;
    end else if (ce) begin
      acc_valid_reg <= stage_tag[LATENCY].valid;
      if (stage_tag[LATENCY].valid) begin
        acc_reg     <= acc_next;
        acc_ovf_reg <= acc_ovf_next;
      end
    end
  end

  assign out_valid = stage_tag[LATENCY].valid;
  assign p         = stage_data[LATENCY];
  assign acc_valid = acc_valid_reg;
  assign acc       = acc_reg;
  assign acc_ovf   = acc_ovf_reg;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Scoreboard bench for mult_acc_pipe: a 48-bit and a 36-bit accumulator instance share stimulus.
module tb_mult_acc_pipe;

  localparam int LAT = 3;

`ifdef MULT_ACC_SAT_EN
  localparam longint OVF36_A = 64'sd34359738367;
  localparam longint OVF36_B = 64'sd34359738367;
`else
  localparam longint OVF36_A = -64'sd34359738368;
  localparam longint OVF36_B = -64'sd34359738367;
`endif
  localparam longint P34 = 64'sd17179869184;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               ce;
  logic               in_valid;
  logic signed [17:0] a;
  logic signed [17:0] b;
  logic               acc_clr;

  logic               ov48, av48, ovf48;
  logic signed [35:0] p48;
  logic signed [47:0] acc48;
  logic               ov36, av36, ovf36;
  logic signed [35:0] p36;
  logic signed [35:0] acc36;

  mult_acc_pipe u_dut48 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_clr(acc_clr), .out_valid(ov48), .p(p48), .acc_valid(av48), .acc(acc48),
    .acc_ovf(ovf48)
  );

  mult_acc_pipe #(.ACC_WIDTH(36)) u_dut36 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_clr(acc_clr), .out_valid(ov36), .p(p36), .acc_valid(av36), .acc(acc36),
    .acc_ovf(ovf36)
  );

  typedef struct { longint p; int cyc; } p_exp_t;
  typedef struct { longint a48; logic o48; longint a36; logic o36; int cyc; } acc_exp_t;

  p_exp_t   p_q[$];
  acc_exp_t acc_q[$];
  int       checks = 0;
  int       errors = 0;
  int       en_cnt = 0;
  logic     ce_edge;
  longint   last_p = 0;
  logic [161:0] snap = '0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (enabled edge %0d)", name, act, exp, en_cnt);
    end
  endtask

  task automatic monitor_step();
    logic [161:0] now_v;
    now_v = {ov48, p48, av48, acc48, ovf48, ov36, p36, av36, acc36, ovf36};
    if (!ce_edge) begin
      check("stall_hold", now_v === snap, 1);
    end else begin
      if (p_q.size() > 0 && p_q[0].cyc == en_cnt) begin
        p_exp_t e;
        e = p_q.pop_front();
        check("out_valid", ov48, 1);
        check("out_valid36", ov36, 1);
        check("p", p48, e.p);
        check("p36", p36, e.p);
        last_p = e.p;
      end else begin
        check("out_valid_idle", ov48, 0);
        check("out_valid36_idle", ov36, 0);
        check("p_hold", p48, last_p);
      end
      if (acc_q.size() > 0 && acc_q[0].cyc == en_cnt) begin
        acc_exp_t e;
        e = acc_q.pop_front();
        check("acc_valid", av48, 1);
        check("acc_valid36", av36, 1);
        check("acc", acc48, e.a48);
        check("acc_ovf", ovf48, e.o48);
        check("acc36", acc36, e.a36);
        check("acc_ovf36", ovf36, e.o36);
      end else begin
        check("acc_valid_idle", av48, 0);
        check("acc_valid36_idle", av36, 0);
      end
    end
    snap = now_v;
  endtask

  // Monitor: count enabled edges and check one time unit after every edge.
  always @(posedge clk) begin
    ce_edge = ce;
    if (ce) en_cnt++;
    #1;
    if (reset_n) monitor_step();
  end

  task automatic send(input longint av, input longint bv, input logic clr, input longint ep,
                      input longint ea48, input logic eo48, input longint ea36,
                      input logic eo36);
    @(posedge clk);
    #2;
    ce       = 1'b1;
    in_valid = 1'b1;
    a        = av[17:0];
    b        = bv[17:0];
    acc_clr  = clr;
    p_q.push_back('{p: ep, cyc: en_cnt + LAT});
    acc_q.push_back('{a48: ea48, o48: eo48, a36: ea36, o36: eo36, cyc: en_cnt + LAT + 1});
    $display("send a=%0d b=%0d clr=%0b -> p=%0d acc48=%0d acc36=%0d ovf36=%0b",
             av, bv, clr, ep, ea48, ea36, eo36);
  endtask

  task automatic idle(input logic ce_v, input logic clr);
    @(posedge clk);
    #2;
    ce       = ce_v;
    in_valid = 1'b0;
    acc_clr  = clr;
    a        = 18'sd77;
    b        = -18'sd5;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, ov48 | ov36, 0);
    check({tag, "_acc_valid"}, av48 | av36, 0);
    check({tag, "_p"}, p48 | p36, 0);
    check({tag, "_acc"}, acc48, 0);
    check({tag, "_acc36"}, acc36, 0);
    check({tag, "_acc_ovf"}, ovf48 | ovf36, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    acc_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    @(posedge clk);
    #3 reset_n = 1'b1;
    idle(1'b1, 1'b0);

    // Back-to-back stream, then the same stream with a two-cycle ce stall after the 2nd sample.
    send(-19, 253, 1'b1, -4807, -4807, 1'b0, -4807, 1'b0);
    send(-22, -33, 1'b0, 726, -4081, 1'b0, -4081, 1'b0);
    send(-35, 46, 1'b0, -1610, -5691, 1'b0, -5691, 1'b0);
    send(8, 9, 1'b0, 72, -5619, 1'b0, -5619, 1'b0);
    idle(1'b1, 1'b0);
    send(-19, 253, 1'b1, -4807, -4807, 1'b0, -4807, 1'b0);
    send(-22, -33, 1'b0, 726, -4081, 1'b0, -4081, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    send(-35, 46, 1'b0, -1610, -5691, 1'b0, -5691, 1'b0);
    send(8, 9, 1'b0, 72, -5619, 1'b0, -5619, 1'b0);

    // Frame restart, corner products, and a clr on a bubble that must be ignored.
    send(3, 4, 1'b1, 12, 12, 1'b0, 12, 1'b0);
    send(-131072, -131072, 1'b1, P34, P34, 1'b0, P34, 1'b0);
    idle(1'b1, 1'b1);
    send(131071, -131072, 1'b0, -64'sd17179738112, 131072, 1'b0, 131072, 1'b0);

    // Overflow of the 36-bit accumulator, sticky flag, then clear and re-overflow.
    send(-131072, -131072, 1'b1, P34, P34, 1'b0, P34, 1'b0);
    send(-131072, -131072, 1'b0, P34, 2 * P34, 1'b0, OVF36_A, 1'b1);
    send(1, 1, 1'b0, 1, 2 * P34 + 1, 1'b0, OVF36_B, 1'b1);
    send(-131072, -131072, 1'b1, P34, P34, 1'b0, P34, 1'b0);
    send(-131072, -131072, 1'b0, P34, 2 * P34, 1'b0, OVF36_A, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Reset with two samples in flight: everything clears at once and nothing stale emerges.
    send(5, 6, 1'b1, 30, 30, 1'b0, 30, 1'b0);
    send(7, 7, 1'b0, 49, 79, 1'b0, 79, 1'b0);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    p_q.delete();
    acc_q.delete();
    last_p = 0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) idle(1'b1, 1'b0);
    send(2, 3, 1'b1, 6, 6, 1'b0, 6, 1'b0);
    send(-4, 5, 1'b0, -20, -14, 1'b0, -14, 1'b0);
    repeat (8) idle(1'b1, 1'b0);

    check("drain", p_q.size() + acc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_acc_pipe.md
Name: mult_acc_pipe

Overview:
- Parametrised, pipelined signed multiplier with a per-sample valid flag, clock enable and an optional running accumulator.
- Next generation of the fixed 18x18, latency-3 DSP multiplier used in the FPGA user datapath.
- Adds configurable operand widths and latency, valid tracking, frame-based multiply-accumulate and an overflow flag.
- Sits between the sample front-end and the filter/correlator logic, and maps onto DSP48 slices.

Parameters:
- A_WIDTH, 18, signed width of operand a (2..25)
- B_WIDTH, 18, signed width of operand b (2..18)
- LATENCY, 3, cycles from accepted input to product output (1..4)
- ACC_WIDTH, 48, signed accumulator width (>= A_WIDTH+B_WIDTH)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ce  input  1  clock enable; 0 freezes every pipeline and accumulator register
- in_valid  input  1  a/b carry a sample this cycle
- a  input  A_WIDTH  signed operand
- b  input  B_WIDTH  signed operand
- acc_clr  input  1  sample is the first of a new accumulation frame (qualified by in_valid)
- out_valid  output  1  p holds a valid product
- p  output  A_WIDTH+B_WIDTH  signed product a*b
- acc_valid  output  1  acc updated this cycle
- acc  output  ACC_WIDTH  signed running sum of products
- acc_ovf  output  1  sticky: accumulator overflowed within the current frame

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low. Assertion clears all registers immediately. Deassertion is synchronised externally.
- Reset values: out_valid=0, p=0, acc_valid=0, acc=0, acc_ovf=0, all internal pipeline stages and valid/clr tags=0.
- Product pipeline: LATENCY register stages carry {valid, clr_tag, data}.
  - Sample accepted when ce=1 at a rising edge.
  - in_valid=1 at accept edge k -> out_valid=1 and p=a*b after LATENCY further enabled edges.
  - in_valid=0 samples propagate as bubbles: out_valid=0, and p holds its last valid value.
- Arithmetic: full-precision signed product, no truncation. (-2^(A-1))*(-2^(B-1)) = 2^(A+B-2) fits in A_WIDTH+B_WIDTH bits.
- ce=0: no register changes, including valid bits. Outputs hold. Latency counts enabled edges only.
- Accumulator: one extra registered stage after p.
  - On an enabled edge with out_valid=1: acc <= (clr_tag ? 0 : acc) + sext(p), and acc_valid <= 1.
  - Otherwise acc holds and acc_valid <= 0.
  - acc_valid is asserted exactly LATENCY+1 enabled cycles after the input.
- acc_clr with in_valid=0 is ignored; the clr tag is only captured with valid data.
- Back-to-back valids: full throughput, one product and one accumulate per cycle, no stalls.
- Overflow detection: signed overflow of the accumulator add (operands same sign, result sign differs).
  - Sets acc_ovf.
  - acc_ovf is cleared by a clr-tagged update, then re-evaluated on that same update.
- Default overflow response: acc wraps (two's complement).
- Reset mid-operation: in-flight samples are discarded. After release, out_valid stays 0 until new valid inputs have traversed LATENCY stages.
- LATENCY out of range or ACC_WIDTH < A_WIDTH+B_WIDTH: elaboration error (generate-time check).

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- Defined: on overflow, acc saturates to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) according to the operand sign. acc_ovf behaves as above. Saturation is combinational in the accumulate stage, so latency is unchanged.
- Undefined: acc wraps. acc_ovf is still generated.

Decomposition:
- Package mult_acc_pkg: LATENCY_MIN=1, LATENCY_MAX=4, default width constants, and a function returning the product width (A_WIDTH+B_WIDTH).
- Sub-module mult_pipe_stage: one ce-gated register stage carrying {valid, clr_tag, data}, parametrised width, reset to 0. It is instantiated via generate LATENCY times; the multiply sits before stage 1.

Test Plan:
- Defaults, ce=1, consecutive valids (-19,253),(-22,-33),(-35,46),(8,9), acc_clr on the first -> p = -4807, 726, -1610, 72 on 4 consecutive cycles, with out_valid high exactly 3 cycles after each input; acc = -4807, -4081, -5691, -5619.
- Corner: a=-131072, b=-131072 -> p=17179869184; a=131071, b=-131072 -> p=-17179738112.
- ce stall: ce=0 for 2 cycles immediately after the 2nd input of the stream above -> all outputs frozen during the stall, each result delayed by exactly 2 cycles, values unchanged.
- Frame restart: after acc=-5619, send (3,4) with acc_clr=1 -> acc=12, acc_ovf=0.
- Overflow with ACC_WIDTH=36: two products of 2^34 in one frame -> acc_ovf=1.
  - Without MULT_ACC_SAT_EN: acc=-34359738368.
  - With MULT_ACC_SAT_EN: acc=34359738367.
- Reset mid-stream: drop reset_n low with 2 samples in flight -> out_valid, acc_valid, acc and acc_ovf are 0 asynchronously; no stale product appears after release; next valid input yields out_valid after 3 cycles.
